// File: rtl/bus_term_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_term_adapter: per-terminal TX/RX show-ahead FIFOs with error      |
// | counters for one port of the bus driver.                              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+

module bus_term_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       nonempty,
  output logic                       accepted,
  output logic                       dropped,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  // A read on an empty FIFO is ignored, so a same-cycle write never bypasses.
  assign w_do_rd   = rd && (r_count != '0);
  assign w_do_wr   = wr && ((r_count != C_DEPTH) || w_do_rd);
  assign accepted  = w_do_wr;
  assign dropped   = wr && !w_do_wr;
  assign underflow = rd && (r_count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_wr) - CW'(w_do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_do_wr) r_mem[r_wptr] <= wdata;
  end

  assign head     = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign count    = r_count;
  assign full     = (r_count == C_DEPTH);
  assign nonempty = (r_count != '0);
endmodule

module bus_term_adapter #(
  parameter int         WIDTH = 16,
  parameter int         DEPTH = 8,
  parameter logic [7:0] ID    = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   tx_full,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   pndng,
  output logic [WIDTH-1:0]       D_pop,
  input  logic                   pop,
  input  logic                   push,
  input  logic [WIDTH-1:0]       D_push,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rx_valid,
  output logic                   rx_full,
  output logic [7:0]             tx_ovf_cnt,
  output logic [7:0]             rx_ovf_cnt,
  output logic [7:0]             misroute_cnt,
  output logic                   pop_err
);
  logic                   w_tx_accepted;
  logic                   w_tx_dropped;
  logic                   w_tx_underflow;
  logic                   w_rx_accepted;
  logic                   w_rx_dropped;
  logic                   w_rx_underflow;
  logic [$clog2(DEPTH):0] w_rx_count;
  logic [7:0]             w_dest;
  logic                   w_misroute;
  logic                   w_unused_ok;

  bus_term_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .reset(reset), .wr(wr_en), .wdata(wr_data), .rd(pop),
    .head(D_pop), .count(tx_count), .full(tx_full), .nonempty(pndng),
    .accepted(w_tx_accepted), .dropped(w_tx_dropped), .underflow(w_tx_underflow)
  );

  bus_term_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .reset(reset), .wr(push), .wdata(D_push), .rd(rd_en),
    .head(rd_data), .count(w_rx_count), .full(rx_full), .nonempty(rx_valid),
    .accepted(w_rx_accepted), .dropped(w_rx_dropped), .underflow(w_rx_underflow)
  );

  assign w_unused_ok = &{1'b0, w_tx_accepted, w_rx_underflow, w_rx_count};

  // Misrouted packets are still stored; only counted for the scoreboard.
  assign w_dest     = D_push[WIDTH-1 -: 8];
  assign w_misroute = w_rx_accepted && (w_dest != ID) && (w_dest != 8'hFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf_cnt   <= '0;
      rx_ovf_cnt   <= '0;
      misroute_cnt <= '0;
      pop_err      <= 1'b0;
    end else begin
      if (w_tx_dropped && tx_ovf_cnt != 8'hFF)   tx_ovf_cnt   <= tx_ovf_cnt + 8'd1;
      if (w_rx_dropped && rx_ovf_cnt != 8'hFF)   rx_ovf_cnt   <= rx_ovf_cnt + 8'd1;
      if (w_misroute && misroute_cnt != 8'hFF)   misroute_cnt <= misroute_cnt + 8'd1;
      if (w_tx_underflow)                        pop_err      <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bus_term_adapter.sv
`default_nettype none
// Randomized bench for bus_term_adapter against a queue-based reference model.
module tb_bus_term_adapter;
  localparam int         WIDTH = 16;
  localparam int         DEPTH = 8;
  localparam logic [7:0] ID    = 8'h03;

  logic             clk, reset;
  logic             wr_en, pop, push, rd_en;
  logic [WIDTH-1:0] wr_data, D_push;
  logic             tx_full, pndng, rx_valid, rx_full, pop_err;
  logic [3:0]       tx_count;
  logic [WIDTH-1:0] D_pop, rd_data;
  logic [7:0]       tx_ovf_cnt, rx_ovf_cnt, misroute_cnt;

  bus_term_adapter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ID(ID)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full), .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .rd_en(rd_en),
    .rd_data(rd_data), .rx_valid(rx_valid), .rx_full(rx_full),
    .tx_ovf_cnt(tx_ovf_cnt), .rx_ovf_cnt(rx_ovf_cnt),
    .misroute_cnt(misroute_cnt), .pop_err(pop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] m_txq[$];
  logic [WIDTH-1:0] m_rxq[$];
  int m_tx_ovf, m_rx_ovf, m_mis;
  bit m_pop_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_txq.delete();
    m_rxq.delete();
    m_tx_ovf  = 0;
    m_rx_ovf  = 0;
    m_mis     = 0;
    m_pop_err = 0;
  endtask

  // One clock of the behavioural rules, evaluated on the inputs at the edge.
  task automatic model_step();
    bit pop_ok, wr_ok, rd_ok, push_ok;
    pop_ok  = pop && (m_txq.size() > 0);
    wr_ok   = wr_en && (m_txq.size() < DEPTH || pop_ok);
    if (pop && m_txq.size() == 0) m_pop_err = 1;
    if (wr_en && !wr_ok && m_tx_ovf < 255) m_tx_ovf++;
    rd_ok   = rd_en && (m_rxq.size() > 0);
    push_ok = push && (m_rxq.size() < DEPTH || rd_ok);
    if (push && !push_ok && m_rx_ovf < 255) m_rx_ovf++;
    if (push_ok && D_push[15:8] != ID && D_push[15:8] != 8'hFF && m_mis < 255) m_mis++;
    if (pop_ok)  void'(m_txq.pop_front());
    if (wr_ok)   m_txq.push_back(wr_data);
    if (rd_ok)   void'(m_rxq.pop_front());
    if (push_ok) m_rxq.push_back(D_push);
  endtask

  task automatic check_all();
    check("pndng",        32'(pndng),        32'(m_txq.size() > 0));
    check("D_pop",        32'(D_pop),        (m_txq.size() > 0) ? 32'(m_txq[0]) : 32'd0);
    check("tx_full",      32'(tx_full),      32'(m_txq.size() == DEPTH));
    check("tx_count",     32'(tx_count),     32'(m_txq.size()));
    check("rx_valid",     32'(rx_valid),     32'(m_rxq.size() > 0));
    check("rd_data",      32'(rd_data),      (m_rxq.size() > 0) ? 32'(m_rxq[0]) : 32'd0);
    check("rx_full",      32'(rx_full),      32'(m_rxq.size() == DEPTH));
    check("tx_ovf_cnt",   32'(tx_ovf_cnt),   32'(m_tx_ovf));
    check("rx_ovf_cnt",   32'(rx_ovf_cnt),   32'(m_rx_ovf));
    check("misroute_cnt", 32'(misroute_cnt), 32'(m_mis));
    check("pop_err",      32'(pop_err),      32'(m_pop_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit w, input logic [WIDTH-1:0] wd, input bit p,
                       input bit ps, input logic [WIDTH-1:0] dp, input bit r);
    wr_en = w; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = r;
    cycle();
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, '0, 0);
  endtask

  // Asserted between edges to observe the asynchronous clear.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 model_clear();
    check("rst_pndng",    32'(pndng),    32'd0);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    check_all();
    @(negedge clk);
    wr_en = 0; pop = 0; push = 0; rd_en = 0; wr_data = '0; D_push = '0;
    reset = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_pkt();
    logic [7:0] dest;
    case ($urandom_range(0, 2))
      0:       dest = ID;
      1:       dest = 8'hFF;
      default: dest = 8'($urandom);
    endcase
    return {dest, 8'($urandom)};
  endfunction

  initial begin
    reset = 1'b0;
    wr_en = 0; pop = 0; push = 0; rd_en = 0; wr_data = '0; D_push = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;

    repeat (5) idle();
    drive(0, '0, 1, 0, '0, 0);
    check("pop_err_empty", 32'(pop_err), 32'd1);
    check("pndng_after_bad_pop", 32'(pndng), 32'd0);

    drive(1, 16'h0101, 0, 0, '0, 0);
    check("first_write_lat", 32'(D_pop), 32'h0101);
    drive(1, 16'h0202, 0, 0, '0, 0);
    drive(0, '0, 1, 0, '0, 0);
    check("pop1_next", 32'(D_pop), 32'h0202);
    drive(0, '0, 1, 0, '0, 0);
    check("pop2_empty", 32'(pndng), 32'd0);

    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1, 16'(16'h1000 + i), 0, 0, '0, 0);
    check("fill_full",  32'(tx_full),  32'd1);
    check("fill_count", 32'(tx_count), 32'd8);
    drive(1, 16'hAAAA, 0, 0, '0, 0);
    check("ovf_no_pop", 32'(tx_ovf_cnt), 32'd1);
    drive(1, 16'hBBBB, 1, 0, '0, 0);
    check("full_wr_pop_count", 32'(tx_count), 32'd8);
    check("full_wr_pop_head",  32'(D_pop),    32'h1001);

    drive(0, '0, 0, 1, 16'h0311, 0);
    drive(0, '0, 0, 1, 16'hFF22, 0);
    drive(0, '0, 0, 1, 16'h0533, 0);
    check("misroute", 32'(misroute_cnt), 32'd1);
    check("rd0", 32'(rd_data), 32'h0311);
    drive(0, '0, 0, 0, '0, 1);
    check("rd1", 32'(rd_data), 32'hFF22);
    drive(0, '0, 0, 0, '0, 1);
    check("rd2", 32'(rd_data), 32'h0533);
    drive(0, '0, 0, 0, '0, 1);
    check("rd_empty", 32'(rx_valid), 32'd0);
    drive(0, '0, 0, 0, '0, 1);

    for (int i = 0; i < DEPTH + 300; i++) drive(0, '0, 0, 1, rnd_pkt(), 0);
    check("rx_ovf_sat", 32'(rx_ovf_cnt), 32'd255);

    do_reset();
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 55, rnd_pkt(), $urandom_range(0, 99) < 45);

    do_reset();
    for (int i = 0; i < 20; i++)
      drive($urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 50, 0, '0, 0);
    wr_en = 1; pop = 1;
    do_reset();
    drive(1, 16'h5A5A, 0, 0, '0, 0);
    check("post_reset_head", 32'(D_pop), 32'h5A5A);
    drive(1, 16'hA5A5, 1, 0, '0, 0);
    check("post_reset_next", 32'(D_pop), 32'hA5A5);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
